multi_axis_fir_path: RTL and testbench

MULTI_AXIS_FIR_PATH -- requirements
Module: multi_axis_fir_path

---
 rtl/multi_axis_fir_path.sv | 204 ++++++++++++++++++++
 tb/tb_multi_axis_fir_path.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_axis_fir_path.sv
// multi_axis_fir_path: per-sample-tick fetch of NUM_CH sensor channels, then
// a TAPS-deep FIR per channel evaluated on one shared multiplier, with
// per-channel selectable coefficient banks (unsigned Q0.16).
// Optional feature: define FIR_SATURATE_EN to clamp results to the signed
// DATA_W range; otherwise results wrap (low DATA_W bits of acc >>> 16).
module multi_axis_fir_path #(
    parameter int NUM_CH     = 3,
    parameter int TAPS       = 16,
    parameter int BANKS      = 4,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_DIV = 49999
) (
    input  logic                                sys_clk,
    input  logic                                rst_n,
    input  logic                                sensor_ready,
    output logic                                sensor_fetch,
    input  logic                                sensor_busy,
    input  logic [NUM_CH*DATA_W-1:0]            sensor_data,
    input  logic [NUM_CH*$clog2(BANKS)-1:0]     bank_sel,
    input  logic                                coef_we,
    input  logic [2:0]                          coef_ch,
    input  logic [$clog2(BANKS)-1:0]            coef_bank,
    input  logic [$clog2(TAPS)-1:0]             coef_idx,
    input  logic [15:0]                         coef_wdata,
    output logic [NUM_CH*DATA_W-1:0]            filt_data,
    output logic                                filt_valid,
    output logic                                available,
    output logic                                data_interrupt,
    output logic                                overrun
);

    localparam int BW   = $clog2(BANKS);
    localparam int TW   = $clog2(TAPS);
    localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int N    = NUM_CH * TAPS;
    localparam int AW   = DATA_W + 16 + TW + 1;
    localparam int PW   = DATA_W + 17;
    localparam int CNTW = (SAMPLE_DIV > 0) ? $clog2(SAMPLE_DIV + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_LOAD, S_MAC, S_STORE, S_DONE
    } state_t;

    state_t                    state;
    logic [CNTW-1:0]           tick_cnt;
    logic                      tick;
    logic [15:0]               coef     [NUM_CH][BANKS][TAPS];
    logic signed [DATA_W-1:0]  dly      [NUM_CH][TAPS];
    logic [BW-1:0]             bank_lat [NUM_CH];
    logic [DATA_W-1:0]         res      [NUM_CH];
    logic [TW+CW-1:0]          mac_cnt;
    logic [TW-1:0]             tap_idx;
    logic [CW-1:0]             ch_idx;
    logic signed [DATA_W-1:0]  tap_samp [NUM_CH];
    logic [15:0]               tap_coef [NUM_CH];
    logic signed [DATA_W-1:0]  mac_samp;
    logic [15:0]               mac_coef;
    logic signed [PW-1:0]      prod;
    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      acc_sum;
    logic signed [AW-1:0]      acc_sh;
    logic [DATA_W-1:0]         mac_res;

    assign tick    = (tick_cnt == CNTW'(SAMPLE_DIV));
    assign tap_idx = mac_cnt[TW-1:0];
    assign ch_idx  = mac_cnt[TW+CW-1:TW];

    // free-running sample tick divider, independent of the FSM
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // coefficient store; a write lands at the edge, so a same-cycle MAC read sees the old word
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int b = 0; b < BANKS; b++)
                    for (int t = 0; t < TAPS; t++)
                        coef[c][b][t] <= (b == 0 && t == 0) ? 16'hFFFF : 16'h0000;
        end else if (coef_we) begin
            for (int c = 0; c < NUM_CH; c++)
                if (coef_ch == 3'(c))
                    coef[c][coef_bank][coef_idx] <= coef_wdata;
        end
    end

    // per-channel operand taps; the latched bank keeps later bank_sel edits out of this sample
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign tap_samp[c] = dly[c][tap_idx];
        assign tap_coef[c] = coef[c][bank_lat[c]][tap_idx];
    end

    assign mac_samp = tap_samp[ch_idx];
    assign mac_coef = tap_coef[ch_idx];
    // coefficient is unsigned: zero-extend before the signed multiply
    assign prod     = PW'(mac_samp) * PW'($signed({1'b0, mac_coef}));
    assign acc_sum  = acc + AW'(prod);
    assign acc_sh   = acc_sum >>> 16;

`ifdef FIR_SATURATE_EN
    localparam logic signed [AW-1:0] RMAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] RMIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // clamp the scaled accumulator into the signed result range
    always_comb begin
        mac_res = acc_sh[DATA_W-1:0];
        if (acc_sh > RMAX)
            mac_res = RMAX[DATA_W-1:0];
        else if (acc_sh < RMIN)
            mac_res = RMIN[DATA_W-1:0];
    end
`else
    logic unused_acc_hi;
    assign unused_acc_hi = &{1'b0, acc_sh[AW-1:DATA_W]};
    // wrap: keep only the low DATA_W bits of the scaled accumulator
    assign mac_res = acc_sh[DATA_W-1:0];
`endif

    // sequencing FSM: fetch handshake, delay-line load, serial MAC, result publish
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            sensor_fetch   <= 1'b0;
            filt_data      <= '0;
            filt_valid     <= 1'b0;
            available      <= 1'b1;
            data_interrupt <= 1'b0;
            overrun        <= 1'b0;
            mac_cnt        <= '0;
            acc            <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                bank_lat[c] <= '0;
                res[c]      <= '0;
                for (int t = 0; t < TAPS; t++)
                    dly[c][t] <= '0;
            end
        end else begin
            filt_valid     <= 1'b0;
            data_interrupt <= 1'b0;
            // a tick while busy is dropped, only flagged
            overrun        <= tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (tick && sensor_ready) begin
                        state        <= S_FETCH_REQ;
                        sensor_fetch <= 1'b1;
                        available    <= 1'b0;
                    end
                end
                S_FETCH_REQ: begin
                    if (sensor_busy) begin
                        state        <= S_FETCH_WAIT;
                        sensor_fetch <= 1'b0;
                    end
                end
                S_FETCH_WAIT: begin
                    if (!sensor_busy)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        dly[c][0]   <= sensor_data[c*DATA_W +: DATA_W];
                        for (int t = 1; t < TAPS; t++)
                            dly[c][t] <= dly[c][t-1];
                        bank_lat[c] <= bank_sel[c*BW +: BW];
                    end
                    mac_cnt <= '0;
                    acc     <= '0;
                    state   <= S_MAC;
                end
                S_MAC: begin
                    // channel-major walk; close out a channel on its last tap
                    if (tap_idx == TW'(TAPS - 1)) begin
                        res[ch_idx] <= mac_res;
                        acc         <= '0;
                    end else begin
                        acc <= acc_sum;
                    end
                    mac_cnt <= mac_cnt + 1'b1;
                    if (mac_cnt == (TW+CW)'(N - 1))
                        state <= S_STORE;
                end
                S_STORE: begin
                    for (int c = 0; c < NUM_CH; c++)
                        filt_data[c*DATA_W +: DATA_W] <= res[c];
                    filt_valid <= 1'b1;
                    available  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    data_interrupt <= 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_axis_fir_path.sv
// Randomized bench for multi_axis_fir_path against a direct arithmetic
// FIR reference (history arrays, coefficient table, floor(sum / 2^16)).
module tb_multi_axis_fir_path;

    localparam int NUM_CH     = 3;
    localparam int TAPS       = 16;
    localparam int BANKS      = 4;
    localparam int DATA_W     = 16;
    localparam int SAMPLE_DIV = 99;
    localparam int BW         = $clog2(BANKS);
    localparam int TW         = $clog2(TAPS);
    localparam int N          = NUM_CH * TAPS;

    logic                       sys_clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       sensor_ready = 1'b0;
    logic                       sensor_busy = 1'b0;
    logic                       sensor_fetch;
    logic [NUM_CH*DATA_W-1:0]   sensor_data = '0;
    logic [NUM_CH*BW-1:0]       bank_sel = '0;
    logic                       coef_we = 1'b0;
    logic [2:0]                 coef_ch = '0;
    logic [BW-1:0]              coef_bank = '0;
    logic [TW-1:0]              coef_idx = '0;
    logic [15:0]                coef_wdata = '0;
    logic [NUM_CH*DATA_W-1:0]   filt_data;
    logic                       filt_valid;
    logic                       available;
    logic                       data_interrupt;
    logic                       overrun;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     tcnt;
    int     mcoef [NUM_CH][BANKS][TAPS];
    longint mh    [NUM_CH][TAPS];
    longint ex    [NUM_CH];

    multi_axis_fir_path #(
        .NUM_CH(NUM_CH), .TAPS(TAPS), .BANKS(BANKS),
        .DATA_W(DATA_W), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .sensor_ready(sensor_ready), .sensor_fetch(sensor_fetch),
        .sensor_busy(sensor_busy), .sensor_data(sensor_data),
        .bank_sel(bank_sel),
        .coef_we(coef_we), .coef_ch(coef_ch), .coef_bank(coef_bank),
        .coef_idx(coef_idx), .coef_wdata(coef_wdata),
        .filt_data(filt_data), .filt_valid(filt_valid), .available(available),
        .data_interrupt(data_interrupt), .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // reference tick timeline: counts 0..SAMPLE_DIV from reset release
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= 0;
        else
            tcnt <= (tcnt == SAMPLE_DIV) ? 0 : tcnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < TAPS; t++) begin
                mh[c][t] = 0;
                for (int b = 0; b < BANKS; b++)
                    mcoef[c][b][t] = (b == 0 && t == 0) ? 65535 : 0;
            end
    endtask

    // push one sample per channel into history, compute the expected outputs
    task automatic model_load(input logic [NUM_CH*DATA_W-1:0] d, input logic [NUM_CH*BW-1:0] bs);
        for (int c = 0; c < NUM_CH; c++) begin
            int     b;
            longint acc;
            longint q;
            for (int t = TAPS - 1; t > 0; t--)
                mh[c][t] = mh[c][t-1];
            mh[c][0] = longint'($signed(d[c*DATA_W +: DATA_W]));
            b   = int'(bs[c*BW +: BW]);
            acc = 0;
            for (int t = 0; t < TAPS; t++)
                acc += mh[c][t] * longint'(mcoef[c][b][t]);
            q = acc >>> 16;
`ifdef FIR_SATURATE_EN
            if (q > longint'(2**(DATA_W-1) - 1))
                q = longint'(2**(DATA_W-1) - 1);
            else if (q < -longint'(2**(DATA_W-1)))
                q = -longint'(2**(DATA_W-1));
`endif
            ex[c] = q & ((longint'(1) << DATA_W) - 1);
        end
    endtask

    task automatic coef_write(input int ch, input int bank, input int idx, input int val);
        coef_we    = 1'b1;
        coef_ch    = 3'(ch);
        coef_bank  = BW'(bank);
        coef_idx   = TW'(idx);
        coef_wdata = 16'(val);
        @(negedge sys_clk);
        coef_we = 1'b0;
        if (ch < NUM_CH)
            mcoef[ch][bank][idx] = val & 16'hFFFF;
    endtask

    task automatic check_reset_outs(input string pfx);
        check({pfx, "_fetch"}, sensor_fetch, 0);
        check({pfx, "_data"}, filt_data, 0);
        check({pfx, "_valid"}, filt_valid, 0);
        check({pfx, "_avail"}, available, 1);
        check({pfx, "_irq"}, data_interrupt, 0);
        check({pfx, "_ovr"}, overrun, 0);
    endtask

    function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
        logic [NUM_CH*DATA_W-1:0] d;
        for (int c = 0; c < NUM_CH; c++) begin
            case ($urandom_range(0, 5))
                0:       d[c*DATA_W +: DATA_W] = 16'h7FFF;
                1:       d[c*DATA_W +: DATA_W] = 16'h8000;
                default: d[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            endcase
        end
        return d;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] const_data(input logic [DATA_W-1:0] v);
        logic [NUM_CH*DATA_W-1:0] d;
        for (int c = 0; c < NUM_CH; c++)
            d[c*DATA_W +: DATA_W] = v;
        return d;
    endfunction

    // one full sensor transaction; act: 0 plain, 1 bank/coef change mid-MAC,
    // 2 reset mid-MAC, 3 sensor_ready dropped mid-operation
    task automatic run_sample(input logic [NUM_CH*DATA_W-1:0] d, input int stall,
                              input int act, input bit chk_ov);
        bit ok;
        int lat;
        int exp_ov;
        int obs_ov;
        int nv;
        int nb;
        ok = 1'b0;
        for (int i = 0; i < 3 * (SAMPLE_DIV + 1); i++) begin
            @(negedge sys_clk);
            if (sensor_fetch) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch_seen", ok, 1);
        if (!ok) return;
        check("avail_low", available, 0);
        exp_ov = (tcnt == SAMPLE_DIV) ? 1 : 0;
        obs_ov = 0;
        sensor_busy = 1'b1;
        if (act == 3) sensor_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge sys_clk);
            if (overrun) obs_ov++;
            if (tcnt == SAMPLE_DIV) exp_ov++;
        end
        @(negedge sys_clk);
        if (overrun) obs_ov++;
        check("fetch_drop", sensor_fetch, 0);
        sensor_data = d;
        sensor_busy = 1'b0;
        model_load(d, bank_sel);
        // lat counts rising edges from this busy drop: one edge to leave the
        // wait state, then the valid strobe lands NUM_CH*TAPS+2 edges later
        lat = 0;
        while (lat < N + 20) begin
            @(negedge sys_clk);
            lat++;
            if (act == 1 && lat == 5) begin
                for (int c = 0; c < NUM_CH; c++)
                    bank_sel[c*BW +: BW] = bank_sel[c*BW +: BW] + 1'b1;
                nb         = int'(bank_sel[BW-1:0]);
                coef_we    = 1'b1;
                coef_ch    = 3'd0;
                coef_bank  = BW'(nb);
                coef_idx   = '0;
                coef_wdata = 16'($urandom_range(1, 65535));
                mcoef[0][nb][0] = int'(coef_wdata);
            end
            if (act == 1 && lat == 6) coef_we = 1'b0;
            if (act == 2 && lat == 10) begin
                rst_n = 1'b0;
                break;
            end
            if (filt_valid) break;
        end
        if (act == 2) begin
            @(negedge sys_clk);
            check_reset_outs("midrst");
            rst_n = 1'b1;
            model_reset();
            nv = 0;
            repeat (N + 10) begin
                @(negedge sys_clk);
                if (filt_valid) nv++;
            end
            check("abort_no_valid", nv, 0);
            return;
        end
        check("latency", lat, N + 3);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("data_ch%0d", c), filt_data[c*DATA_W +: DATA_W], ex[c]);
        check("avail_hi", available, 1);
        check("irq_early", data_interrupt, 0);
        @(negedge sys_clk);
        check("irq", data_interrupt, 1);
        check("valid_pulse", filt_valid, 0);
        if (chk_ov) check("overruns", obs_ov, exp_ov);
        if (act == 3) sensor_ready = 1'b1;
    endtask

    initial begin
        int nv;
        int nf;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_reset_outs("reset");
        rst_n = 1'b1;
        sensor_ready = 1'b1;

        // default coefficients: tap 0 of bank 0 only
        run_sample({DATA_W'($urandom), DATA_W'($urandom), 16'h0100}, 2, 0, 0);

        // moving average via bank 1, constant input
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < TAPS; t++)
                coef_write(c, 1, t, 16'h1000);
        for (int c = 0; c < NUM_CH; c++)
            bank_sel[c*BW +: BW] = BW'(1);
        for (int i = 0; i < TAPS; i++)
            run_sample(const_data(16'h0400), 1, 0, 0);

        // large gain overflow: wrap or clamp
        for (int c = 0; c < NUM_CH; c++)
            for (int t = 0; t < TAPS; t++)
                coef_write(c, 1, t, 16'h8000);
        for (int i = 0; i < TAPS; i++)
            run_sample(const_data(16'h7FFF), 1, 0, 0);

        // random coefficients, banks, samples (includes ignored channel writes)
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 6))
                coef_write($urandom_range(0, 7), $urandom_range(0, BANKS - 1),
                           $urandom_range(0, TAPS - 1), $urandom_range(0, 65535));
            bank_sel = (NUM_CH*BW)'($urandom);
            run_sample(rand_data(), $urandom_range(1, 6), 0, 0);
        end

        // bank switch plus coefficient write during MAC, then a sample on the new bank
        run_sample(rand_data(), 2, 1, 0);
        run_sample(rand_data(), 2, 0, 0);

        // sensor_ready drop mid-operation does not abort
        run_sample(rand_data(), 3, 3, 0);

        // long busy stall: every tick during it is an overrun, one result only
        run_sample(rand_data(), 250, 0, 1);

        // ticks with sensor_ready low start nothing
        sensor_ready = 1'b0;
        nv = 0;
        nf = 0;
        repeat (2 * (SAMPLE_DIV + 1) + 5) begin
            @(negedge sys_clk);
            if (filt_valid) nv++;
            if (sensor_fetch) nf++;
        end
        check("idle_no_valid", nv, 0);
        check("idle_no_fetch", nf, 0);
        sensor_ready = 1'b1;

        // reset mid-MAC, then a fresh sample from zeroed history and reset coefficients
        run_sample(rand_data(), 2, 2, 0);
        bank_sel = '0;
        run_sample(rand_data(), 2, 0, 0);
        run_sample(rand_data(), 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
